// File: rtl/sio_pkg.sv
// Shared definitions for the serial burst slave: FSM states, command byte
// bit positions and the response header width.
package sio_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam int CMD_START   = 7;
  localparam int CMD_BURST   = 6;
  localparam int CMD_READ    = 5;
  localparam int CMD_RSVD    = 4;
  localparam int CMD_ALEN_HI = 3;
  localparam int CMD_ALEN_LO = 2;

  // Start bit plus status bit
  localparam int RESP_HDR_W = 2;

  // Bits of the address that come from the serial stream for a given length code
  function automatic logic [31:0] addr_mask(input logic [1:0] alen);
    logic [31:0] m;
    case (alen)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      2'd2:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sio_resp_tx.sv
// Response serialiser: shifts start bit, status bit and optional read data
// out MSB first; done marks the cycle carrying the final bit.
module sio_resp_tx
  import sio_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic              status,
  input  logic              with_data,
  input  logic [DATA_W-1:0] data,
  output logic              si,
  output logic              done
);

  localparam int FRAME_W = RESP_HDR_W + DATA_W;
  localparam int CW      = $clog2(FRAME_W);

  logic [FRAME_W-1:0] sh_reg;
  logic [CW-1:0]      left_reg;
  logic               active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg     <= '0;
      left_reg   <= '0;
      active_reg <= 1'b0;
    end else if (abort) begin
      active_reg <= 1'b0;
    end else if (load) begin
      sh_reg     <= {1'b1, status, data};
      left_reg   <= with_data ? CW'(FRAME_W - 1) : CW'(RESP_HDR_W - 1);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      sh_reg <= {sh_reg[FRAME_W-2:0], 1'b0};
      if (left_reg == '0) active_reg <= 1'b0;
      else                left_reg   <= left_reg - 1'b1;
    end
  end

  assign si   = active_reg & sh_reg[FRAME_W-1];
  assign done = active_reg && (left_reg == '0);

endmodule

// File: rtl/sio_burst_slave.sv
// Serial-to-register bridge: decodes framed commands on SO into single or
// burst register accesses and reports a per-access status on SI.
module sio_burst_slave
  import sio_pkg::*;
#(
  parameter int DATA_BYTES  = 1,
  parameter int ADDR_STEP   = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    SCK,
  input  logic                    RSTn,
  input  logic [31:0]             FILL_ADDR,
  input  logic                    SCS,
  input  logic                    SO,
  output logic                    SI,
  output logic [31:0]             REG_ADDR,
  output logic [8*DATA_BYTES-1:0] REG_WD,
  output logic                    REG_WE,
  output logic                    REG_RE,
  input  logic                    REG_ACK,
  input  logic                    REG_RV,
  input  logic [8*DATA_BYTES-1:0] REG_RD,
  output logic                    BUSY,
  output logic                    TIMEOUT_ERR
);

  localparam int DATA_W = 8 * DATA_BYTES;

  state_t             state_reg, state_next;
  logic [5:0]         bit_left_reg;
  logic [31:0]        sh_reg;
  logic               burst_reg, read_reg;
  logic [1:0]         alen_reg;
  logic [8:0]         remain_reg;
  logic [15:0]        tcnt_reg;
  logic [31:0]        addr_reg;
  logic [DATA_W-1:0]  wd_reg;

  logic [31:0]        sh_next;
  logic [7:0]         cmd_full;
  logic               last_bit, ack_now, tmo_now, tx_load, tx_done, tx_si;
  logic [DATA_W-1:0]  resp_data;

  // The start bit is preloaded in IDLE so the full command byte sits in sh_next
  assign sh_next   = {sh_reg[30:0], SO};
  assign cmd_full  = sh_next[7:0];
  assign last_bit  = (bit_left_reg == 6'd0);
  assign ack_now   = (state_reg == ST_ISSUE || state_reg == ST_WAIT) && REG_ACK;
  assign tmo_now   = (state_reg == ST_WAIT) && !REG_ACK && (tcnt_reg == 16'(ACK_TIMEOUT));
  assign tx_load   = SCS && (ack_now || tmo_now);
  assign resp_data = (ack_now && REG_RV) ? REG_RD : '1;

  always_ff @(posedge SCK or negedge RSTn) begin
    if (!RSTn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!SCS) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (SO) state_next = ST_CMD;
        ST_CMD:   if (last_bit)
                    state_next = (cmd_full[CMD_RSVD] || !cmd_full[CMD_START]) ? ST_DONE : ST_ADDR;
        ST_ADDR:  if (last_bit)
                    state_next = burst_reg ? ST_LEN : (read_reg ? ST_ISSUE : ST_DATA);
        ST_LEN:   if (last_bit) state_next = read_reg ? ST_ISSUE : ST_DATA;
        ST_DATA:  if (last_bit) state_next = ST_ISSUE;
        ST_ISSUE: state_next = REG_ACK ? ST_RESP : ST_WAIT;
        ST_WAIT:  if (ack_now || tmo_now) state_next = ST_RESP;
        ST_RESP:  if (tx_done)
                    state_next = (remain_reg == 9'd1) ? ST_DONE : (read_reg ? ST_ISSUE : ST_DATA);
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SCK or negedge RSTn) begin
    if (!RSTn) begin
      bit_left_reg <= '0;
      sh_reg       <= '0;
      burst_reg    <= 1'b0;
      read_reg     <= 1'b0;
      alen_reg     <= '0;
      remain_reg   <= '0;
      tcnt_reg     <= '0;
      addr_reg     <= '0;
      wd_reg       <= '0;
    end else if (SCS) begin
      case (state_reg)
        ST_IDLE: begin
          sh_reg       <= 32'd1;
          bit_left_reg <= 6'd6;
        end
        ST_CMD: begin
          sh_reg <= sh_next;
          if (last_bit) begin
            burst_reg    <= cmd_full[CMD_BURST];
            read_reg     <= cmd_full[CMD_READ];
            alen_reg     <= cmd_full[CMD_ALEN_HI:CMD_ALEN_LO];
            bit_left_reg <= {1'b0, cmd_full[CMD_ALEN_HI:CMD_ALEN_LO], 3'b111};
          end else begin
            bit_left_reg <= bit_left_reg - 6'd1;
          end
        end
        ST_ADDR: begin
          sh_reg <= sh_next;
          if (last_bit) begin
            addr_reg     <= (FILL_ADDR & ~addr_mask(alen_reg)) | (sh_next & addr_mask(alen_reg));
            remain_reg   <= 9'd1;
            bit_left_reg <= burst_reg ? 6'd7 : 6'(DATA_W - 1);
          end else begin
            bit_left_reg <= bit_left_reg - 6'd1;
          end
        end
        ST_LEN: begin
          sh_reg <= sh_next;
          if (last_bit) begin
            remain_reg   <= {1'b0, sh_next[7:0]} + 9'd1;
            bit_left_reg <= 6'(DATA_W - 1);
          end else begin
            bit_left_reg <= bit_left_reg - 6'd1;
          end
        end
        ST_DATA: begin
          wd_reg <= {wd_reg[DATA_W-2:0], SO};
          if (!last_bit) bit_left_reg <= bit_left_reg - 6'd1;
        end
        // Counter holds the number of cycles elapsed since the strobe
        ST_ISSUE: tcnt_reg <= 16'd1;
        ST_WAIT:  tcnt_reg <= tcnt_reg + 16'd1;
        ST_RESP: begin
          if (tx_done) begin
            addr_reg     <= addr_reg + 32'(ADDR_STEP);
            remain_reg   <= remain_reg - 9'd1;
            bit_left_reg <= 6'(DATA_W - 1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    BUSY        = (state_reg != ST_IDLE);
    REG_WE      = 1'b0;
    REG_RE      = 1'b0;
    TIMEOUT_ERR = tmo_now;
    if (state_reg == ST_ISSUE) begin
      REG_WE = !read_reg;
      REG_RE = read_reg;
    end
  end

  assign REG_ADDR = addr_reg;
  assign REG_WD   = wd_reg;
  assign SI       = tx_si;

  sio_resp_tx #(
    .DATA_W(DATA_W)
  ) u_resp_tx (
    .clk       (SCK),
    .rst_n     (RSTn),
    .load      (tx_load),
    .abort     (!SCS),
    .status    (ack_now),
    .with_data (read_reg),
    .data      (resp_data),
    .si        (tx_si),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_sio_burst_slave.sv
// Scoreboard bench for sio_burst_slave (DATA_BYTES=2, ADDR_STEP=2, ACK_TIMEOUT=16).
module tb_sio_burst_slave;

  logic        SCK, RSTn, SCS, SO, SI, REG_WE, REG_RE, REG_ACK, REG_RV, BUSY, TIMEOUT_ERR;
  logic [31:0] FILL_ADDR, REG_ADDR;
  logic [15:0] REG_WD, REG_RD;

  typedef struct packed { logic we; logic [31:0] addr; logic [15:0] wd; } acc_t;
  typedef struct packed { logic st; logic [15:0] d; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt = 0, re_cnt = 0, tmo_cnt = 0, si_cnt = 0;

  sio_burst_slave #(.DATA_BYTES(2), .ADDR_STEP(2), .ACK_TIMEOUT(16)) dut (
    .SCK(SCK), .RSTn(RSTn), .FILL_ADDR(FILL_ADDR), .SCS(SCS), .SO(SO), .SI(SI),
    .REG_ADDR(REG_ADDR), .REG_WD(REG_WD), .REG_WE(REG_WE), .REG_RE(REG_RE),
    .REG_ACK(REG_ACK), .REG_RV(REG_RV), .REG_RD(REG_RD), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial SCK = 1'b0;
  always #5 SCK = ~SCK;

  always @(negedge SCK) begin
    if (REG_WE)      we_cnt  <= we_cnt + 1;
    if (REG_RE)      re_cnt  <= re_cnt + 1;
    if (TIMEOUT_ERR) tmo_cnt <= tmo_cnt + 1;
    if (SI)          si_cnt  <= si_cnt + 1;
  end

  task automatic tick();
    @(posedge SCK);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SO = v[i];
      tick();
    end
    SO = 1'b0;
  endtask

  task automatic end_frame();
    SCS = 1'b0;
    SO  = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_strobe(output int waited, output logic we, output logic re,
                             output logic [31:0] addr, output logic [15:0] wd);
    waited = 0;
    while (!(REG_WE || REG_RE) && waited < 50) begin
      tick();
      waited++;
    end
    we = REG_WE; re = REG_RE; addr = REG_ADDR; wd = REG_WD;
  endtask

  task automatic get_resp(input bit rd, output int waited, output logic st, output logic [15:0] d);
    waited = 0;
    while (SI !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    tick();
    st = SI;
    d  = '0;
    if (rd) for (int i = 0; i < 16; i++) begin
      tick();
      d = {d[14:0], SI};
    end
  endtask

  task automatic test_reset();
    #2 RSTn = 1'b0;
    #1;
    n_checks++;
    if ({SI, REG_WE, REG_RE, BUSY, TIMEOUT_ERR} !== 5'b0) begin
      $display("FAIL reset_ctrl got=%b exp=00000", {SI, REG_WE, REG_RE, BUSY, TIMEOUT_ERR}); n_fail++;
    end
    n_checks++;
    if (REG_ADDR !== 32'h0 || REG_WD !== 16'h0) begin
      $display("FAIL reset_bus got=%h/%h exp=0/0", REG_ADDR, REG_WD); n_fail++;
    end
    repeat (3) @(posedge SCK);
    @(negedge SCK) RSTn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    acc_t a; rsp_t r; int w, we0; logic we, re, st; logic [31:0] ad; logic [15:0] wd, d;
    FILL_ADDR = 32'h1234_5600;
    a.we = 1'b1; a.addr = 32'h1234_5634; a.wd = 16'hA5C3; acc_q.push_back(a);
    r.st = 1'b1; r.d = 16'h0; rsp_q.push_back(r);
    we0 = we_cnt;
    SCS = 1'b1;
    send_bits(32'h80, 8); send_bits(32'h34, 8); send_bits(32'hA5C3, 16);
    wait_strobe(w, we, re, ad, wd);
    a = acc_q.pop_front();
    n_checks++;
    if (w !== 0) begin $display("FAIL wr_strobe_lat got=%0d exp=0", w); n_fail++; end
    n_checks++;
    if ({we, re} !== {a.we, ~a.we}) begin $display("FAIL wr_strobe_kind got=%b exp=%b", {we, re}, {a.we, ~a.we}); n_fail++; end
    n_checks++;
    if (ad !== a.addr) begin $display("FAIL wr_addr got=%h exp=%h", ad, a.addr); n_fail++; end
    n_checks++;
    if (wd !== a.wd) begin $display("FAIL wr_data got=%h exp=%h", wd, a.wd); n_fail++; end
    repeat (3) tick();
    REG_ACK = 1'b1; tick(); REG_ACK = 1'b0;
    get_resp(1'b0, w, st, d);
    r = rsp_q.pop_front();
    n_checks++;
    if (w !== 0 || st !== r.st) begin $display("FAIL wr_resp got=lat%0d,st%b exp=lat0,st%b", w, st, r.st); n_fail++; end
    n_checks++;
    if (we_cnt - we0 !== 1) begin $display("FAIL wr_we_width got=%0d exp=1", we_cnt - we0); n_fail++; end
    end_frame();
    n_checks++;
    if (BUSY !== 1'b0) begin $display("FAIL wr_idle got=%b exp=0", BUSY); n_fail++; end
  endtask

  task automatic test_read_burst();
    acc_t a; rsp_t r; int w, re0; logic we, re, st; logic [31:0] ad; logic [15:0] wd, d;
    FILL_ADDR = 32'hABCD_FF00;
    for (int i = 0; i < 4; i++) begin
      a.we = 1'b0; a.addr = 32'hABCD_0100 + 32'(2 * i); a.wd = 16'h0; acc_q.push_back(a);
      r.st = 1'b1; r.d = 16'hBEEF + 16'(i); rsp_q.push_back(r);
    end
    re0 = re_cnt;
    SCS = 1'b1;
    send_bits(32'hE4, 8); send_bits(32'h0100, 16); send_bits(32'h03, 8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      wait_strobe(w, we, re, ad, wd);
      a = acc_q.pop_front();
      r = rsp_q.pop_front();
      n_checks++;
      if (w !== 0 || re !== 1'b1 || we !== 1'b0) begin
        $display("FAIL rd_burst_strobe%0d got=lat%0d,we%b,re%b exp=lat0,we0,re1", i, w, we, re); n_fail++;
      end
      n_checks++;
      if (ad !== a.addr) begin $display("FAIL rd_burst_addr%0d got=%h exp=%h", i, ad, a.addr); n_fail++; end
      REG_ACK = 1'b1; REG_RV = 1'b1; REG_RD = r.d;
      tick();
      REG_ACK = 1'b0; REG_RV = 1'b0; REG_RD = 16'h0;
      get_resp(1'b1, w, st, d);
      n_checks++;
      if (w !== 0 || st !== r.st || d !== r.d) begin
        $display("FAIL rd_burst_resp%0d got=lat%0d,st%b,%h exp=lat0,st%b,%h", i, w, st, d, r.st, r.d); n_fail++;
      end
    end
    repeat (10) tick();
    n_checks++;
    if (re_cnt - re0 !== 4) begin $display("FAIL rd_burst_count got=%0d exp=4", re_cnt - re0); n_fail++; end
    end_frame();
  endtask

  task automatic test_read_rv0();
    rsp_t r; int w; logic we, re, st; logic [31:0] ad; logic [15:0] wd, d;
    FILL_ADDR = 32'h1234_5600;
    r.st = 1'b1; r.d = 16'hFFFF; rsp_q.push_back(r);
    SCS = 1'b1;
    send_bits(32'hA0, 8); send_bits(32'h7F, 8);
    wait_strobe(w, we, re, ad, wd);
    n_checks++;
    if (re !== 1'b1 || ad !== 32'h1234_567F) begin $display("FAIL rv0_strobe got=re%b,%h exp=re1,1234567f", re, ad); n_fail++; end
    tick();
    REG_ACK = 1'b1; REG_RV = 1'b0; REG_RD = 16'h1234;
    tick();
    REG_ACK = 1'b0; REG_RD = 16'h0;
    get_resp(1'b1, w, st, d);
    r = rsp_q.pop_front();
    n_checks++;
    if (w !== 0 || st !== r.st || d !== r.d) begin
      $display("FAIL rv0_resp got=lat%0d,st%b,%h exp=lat0,st%b,%h", w, st, d, r.st, r.d); n_fail++;
    end
    end_frame();
  endtask

  task automatic test_timeout();
    rsp_t r; int w, early, tmo0; logic we, re, st; logic [31:0] ad; logic [15:0] wd, d;
    r.st = 1'b0; r.d = 16'hFFFF; rsp_q.push_back(r);
    tmo0 = tmo_cnt; early = 0;
    SCS = 1'b1;
    send_bits(32'hA0, 8); send_bits(32'h10, 8);
    wait_strobe(w, we, re, ad, wd);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16 && TIMEOUT_ERR) early++;
    end
    n_checks++;
    if (early !== 0 || TIMEOUT_ERR !== 1'b1) begin
      $display("FAIL tmo_timing got=early%0d,at16=%b exp=early0,at16=1", early, TIMEOUT_ERR); n_fail++;
    end
    fork
      get_resp(1'b1, w, st, d);
      begin repeat (4) tick(); REG_ACK = 1'b1; tick(); REG_ACK = 1'b0; end
    join
    r = rsp_q.pop_front();
    n_checks++;
    if (w !== 1 || st !== r.st || d !== r.d) begin
      $display("FAIL tmo_resp got=lat%0d,st%b,%h exp=lat1,st%b,%h", w, st, d, r.st, r.d); n_fail++;
    end
    repeat (5) tick();
    n_checks++;
    if (tmo_cnt - tmo0 !== 1) begin $display("FAIL tmo_pulses got=%0d exp=1", tmo_cnt - tmo0); n_fail++; end
    end_frame();
  endtask

  task automatic test_abort();
    acc_t a; rsp_t r; int w, re0, tmo0, si0; logic we, re, st; logic [31:0] ad; logic [15:0] wd, d;
    FILL_ADDR = 32'h1234_5600;
    SCS = 1'b1;
    send_bits(32'hE0, 8); send_bits(32'h40, 8); send_bits(32'h05, 8);
    wait_strobe(w, we, re, ad, wd);
    REG_ACK = 1'b1; REG_RV = 1'b1; REG_RD = 16'h0F0F;
    tick();
    REG_ACK = 1'b0; REG_RV = 1'b0;
    get_resp(1'b1, w, st, d);
    n_checks++;
    if (st !== 1'b1 || d !== 16'h0F0F) begin $display("FAIL abort_first got=st%b,%h exp=st1,0f0f", st, d); n_fail++; end
    tick();
    wait_strobe(w, we, re, ad, wd);
    n_checks++;
    if (re !== 1'b1 || ad !== 32'h1234_5642) begin $display("FAIL abort_second got=re%b,%h exp=re1,12345642", re, ad); n_fail++; end
    repeat (3) tick();
    re0 = re_cnt; tmo0 = tmo_cnt; si0 = si_cnt;
    SCS = 1'b0;
    tick();
    n_checks++;
    if (BUSY !== 1'b0 || SI !== 1'b0) begin $display("FAIL abort_idle got=busy%b,si%b exp=busy0,si0", BUSY, SI); n_fail++; end
    repeat (25) tick();
    n_checks++;
    if (re_cnt !== re0 || tmo_cnt !== tmo0 || si_cnt !== si0) begin
      $display("FAIL abort_quiet got=re+%0d,tmo+%0d,si+%0d exp=0,0,0", re_cnt - re0, tmo_cnt - tmo0, si_cnt - si0); n_fail++;
    end
    a.we = 1'b1; a.addr = 32'h1234_5655; a.wd = 16'h1234; acc_q.push_back(a);
    r.st = 1'b1; r.d = 16'h0; rsp_q.push_back(r);
    SCS = 1'b1;
    send_bits(32'h80, 8); send_bits(32'h55, 8); send_bits(32'h1234, 16);
    wait_strobe(w, we, re, ad, wd);
    a = acc_q.pop_front();
    n_checks++;
    if (w !== 0 || we !== a.we || ad !== a.addr || wd !== a.wd) begin
      $display("FAIL abort_next_wr got=lat%0d,we%b,%h,%h exp=lat0,we1,%h,%h", w, we, ad, wd, a.addr, a.wd); n_fail++;
    end
    REG_ACK = 1'b1; tick(); REG_ACK = 1'b0;
    get_resp(1'b0, w, st, d);
    r = rsp_q.pop_front();
    n_checks++;
    if (w !== 0 || st !== r.st) begin $display("FAIL abort_next_resp got=lat%0d,st%b exp=lat0,st1", w, st); n_fail++; end
    end_frame();
  endtask

  task automatic test_reserved();
    int we0, re0, si0;
    we0 = we_cnt; re0 = re_cnt; si0 = si_cnt;
    SCS = 1'b1;
    send_bits(32'h90, 8); send_bits(32'hFFFF_FFFF, 32);
    n_checks++;
    if (we_cnt !== we0 || re_cnt !== re0 || si_cnt !== si0 || BUSY !== 1'b1) begin
      $display("FAIL rsvd_quiet got=we+%0d,re+%0d,si+%0d,busy%b exp=0,0,0,busy1", we_cnt - we0, re_cnt - re0, si_cnt - si0, BUSY); n_fail++;
    end
    end_frame();
    n_checks++;
    if (BUSY !== 1'b0) begin $display("FAIL rsvd_idle got=%b exp=0", BUSY); n_fail++; end
  endtask

  task automatic test_reset_midframe();
    int w; logic we, re; logic [31:0] ad; logic [15:0] wd;
    FILL_ADDR = 32'h1234_5600;
    SCS = 1'b1;
    send_bits(32'h80, 8); send_bits(32'h34, 8); send_bits(32'h5A5A, 16);
    wait_strobe(w, we, re, ad, wd);
    repeat (2) tick();
    n_checks++;
    if (BUSY !== 1'b1 || REG_ADDR !== 32'h1234_5634 || REG_WD !== 16'h5A5A) begin
      $display("FAIL midrst_pre got=busy%b,%h,%h exp=busy1,12345634,5a5a", BUSY, REG_ADDR, REG_WD); n_fail++;
    end
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({SI, REG_WE, REG_RE, BUSY, TIMEOUT_ERR} !== 5'b0 || REG_ADDR !== 32'h0 || REG_WD !== 16'h0) begin
      $display("FAIL midrst_outputs got=%b,%h,%h exp=00000,0,0", {SI, REG_WE, REG_RE, BUSY, TIMEOUT_ERR}, REG_ADDR, REG_WD); n_fail++;
    end
    SCS = 1'b0;
    repeat (2) @(posedge SCK);
    @(negedge SCK) RSTn = 1'b1;
    tick();
  endtask

  initial begin
    RSTn = 1'b1; SCS = 1'b0; SO = 1'b0; REG_ACK = 1'b0; REG_RV = 1'b0;
    REG_RD = 16'h0; FILL_ADDR = 32'h0;
    test_reset();
    test_write();
    test_read_burst();
    test_read_rv0();
    test_timeout();
    test_abort();
    test_reserved();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/sio_burst_slave.md
# sio_burst_slave

Parametrised serial-to-register bridge: the next generation of the SiTCP SIO slave. Decodes framed serial commands on SO into single or burst register accesses of configurable data width, with address auto-increment, ACK timeout and a per-access status response on SI. Sits between the SiTCP serial port and the user register bus; entirely in the SCK domain.

## Interface
- DATA_BYTES, 1: bytes per access (1..4); DATA_W = 8*DATA_BYTES.
- ADDR_STEP, 1: address increment between burst accesses.
- ACK_TIMEOUT, 255: SCK cycles to wait for REG_ACK (1..65535).
---
- SCK  in  1  only clock; all logic on rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- FILL_ADDR  in  32  upper address bits for short addresses.
- SCS  in  1  frame active; sampled synchronously.
- SO  in  1  serial data from master.
- SI  out  1  serial response to master.
- REG_ADDR  out  32  access address.
- REG_WD  out  DATA_W  write data.
- REG_WE  out  1  write strobe, one cycle.
- REG_RE  out  1  read strobe, one cycle.
- REG_ACK  in  1  access acknowledge.
- REG_RV  in  1  read valid, qualified by REG_ACK.
- REG_RD  in  DATA_W  read data, qualified by REG_ACK.
- BUSY  out  1  state not IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse on each timeout.

## Operation
- Bits MSB first. Command byte c: c[7]=1 (start marker), c[6]=burst, c[5]=read, c[4]=reserved (must be 0), c[3:2]=address bytes-1.
- Header: c, then (c[3:2]+1) address bytes (right-justified, upper bits from FILL_ADDR), then one length byte L if c[6] (N=L+1 accesses, 1..256); else N=1.
- States: IDLE, CMD, ADDR, LEN, DATA, ISSUE, WAIT, RESP, DONE.
- IDLE: with SCS=1, first SO=1 is c[7] -> CMD. SO=0 ignored.
- c[4]=1 -> DONE, no access.
- Write: DATA shifts DATA_W bits into REG_WD -> ISSUE (REG_WE). Read: ISSUE (REG_RE) directly after header.
- WAIT: REG_ACK accepted in strobe cycle or later. Counter reaching ACK_TIMEOUT without ACK -> status=0, read data all ones, TIMEOUT_ERR pulse; later ACKs ignored.
- RESP on SI: start bit 1, status bit (1=acked), then for reads DATA_W data bits (REG_RD if REG_RV else all ones). SI=0 outside response.
- After RESP: REG_ADDR += ADDR_STEP (mod 2^32), N decrements; N=0 -> DONE, else read -> ISSUE, write -> DATA.
- SO ignored in ISSUE/WAIT/RESP/DONE; master waits for the response before sending the next write word.
- SCS=0 sampled in any state -> IDLE next cycle; strobes 0, SI 0, pending access abandoned.

## Timing
- Reset: all outputs 0 (REG_ADDR, REG_WD included), state IDLE.
- REG_WE/REG_RE asserted the cycle after the last DATA/header bit is sampled; exactly one cycle.
- REG_ADDR and REG_WD stable from strobe until RESP ends.
- SI start bit in the cycle after ACK is sampled (or timeout).
- Timeout counter cleared at strobe; timeout declared on cycle ACK_TIMEOUT after strobe.
- Per-burst read gap: RESP end -> next REG_RE: 1 cycle.
- Frames separated by >=1 SCK cycle with SCS=0.

## Structure
- Package sio_pkg: state enum, command bit positions, response header width (2).
- Sub-module sio_resp_tx: loads status and data, serialises start/status/data onto SI, signals done.

## Test plan
- Write, 1-byte address 0x34, FILL_ADDR=0x12345600, DATA_BYTES=1, data 0xA5, ACK after 3 cycles -> REG_WE one cycle, REG_ADDR=0x12345634, REG_WD=0xA5; SI=1,1.
- Read burst, 2-byte address 0x0100, L=3, DATA_BYTES=2, ADDR_STEP=2, REG_RD=0xBEEF -> four REG_RE at 0x0100/0102/0104/0106; each response 1,1,0xBEEF.
- Read with REG_RV=0 -> response 1,1,0xFF (DATA_BYTES=1).
- No ACK, ACK_TIMEOUT=16 -> TIMEOUT_ERR pulse 16 cycles after strobe; response 1,0,0xFF; ACK at cycle 20 ignored.
- SCS dropped during WAIT of burst -> IDLE next cycle, no further strobes, SI=0; a new frame then executes normally.
- c[4]=1 -> no strobe, SI stays 0 until SCS=0; RSTn low mid-frame -> all outputs 0 immediately.
